// File: rtl/ecc_pkg.sv
// ecc_pkg: status and FSM state types shared by the ECC correction stages
package ecc_pkg;
    typedef enum logic [1:0] {ST_NONE = 2'd0, ST_CORR = 2'd1, ST_UNCORR = 2'd2} ecc_status_t;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} fsm_state_t;
endpackage

// File: rtl/syndrome_corrector_h_col_select.sv
// h_col_select: extracts column idx of a row-major flattened H matrix
module h_col_select #(
    parameter int CODE_LEN = 8,
    parameter int SYN_LEN  = 4
) (
    input  logic [SYN_LEN*CODE_LEN-1:0]  h_matrix,
    input  logic [$clog2(CODE_LEN)-1:0] idx,
    output logic [SYN_LEN-1:0]           col
);
    for (genvar r = 0; r < SYN_LEN; r++) begin : g_row
        assign col[r] = h_matrix[CODE_LEN*r + int'(idx)];
    end
endmodule

// File: rtl/syndrome_corrector.sv
// syndrome_corrector: single-bit error correction by sequential search of H columns
module syndrome_corrector
    import ecc_pkg::*;
#(
    parameter int CODE_LEN = 8,
    parameter int SYN_LEN  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SYN_LEN*CODE_LEN-1:0]   h_matrix_in,
    input  logic [CODE_LEN-1:0]           word_in,
    input  logic [SYN_LEN-1:0]            syndrome_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CODE_LEN-1:0]           word_out,
    output logic [$clog2(CODE_LEN)-1:0]   err_pos,
    output logic [1:0]                    status,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              corr_cnt,
    output logic [CNT_W-1:0]              uncorr_cnt
);
    localparam int IDX_W = $clog2(CODE_LEN);
    fsm_state_t                  state;
    logic [SYN_LEN*CODE_LEN-1:0] h_reg;
    logic [CODE_LEN-1:0]         word_reg;
    logic [SYN_LEN-1:0]          syn_reg, col;
    logic [IDX_W-1:0]            idx;
    assign in_ready = state == IDLE;
    h_col_select #(.CODE_LEN(CODE_LEN), .SYN_LEN(SYN_LEN)) u_sel (
        .h_matrix(h_reg),
        .idx     (idx),
        .col     (col)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h_reg      <= '0;
            word_reg   <= '0;
            syn_reg    <= '0;
            idx        <= '0;
            word_out   <= '0;
            err_pos    <= '0;
            status     <= ST_NONE;
            out_valid  <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    h_reg    <= h_matrix_in;
                    word_reg <= word_in;
                    syn_reg  <= syndrome_in;
                    idx      <= '0;
                    if (syndrome_in == '0) begin
                        word_out  <= word_in;
                        err_pos   <= '0;
                        status    <= ST_NONE;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    // the first match ends the search, so the lowest duplicate column wins
                    if (col == syn_reg) begin
                        word_out  <= word_reg ^ (CODE_LEN'(1) << idx);
                        err_pos   <= idx;
                        status    <= ST_CORR;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
                    end else if (idx == IDX_W'(CODE_LEN-1)) begin
                        word_out  <= word_reg;
                        err_pos   <= '0;
                        status    <= ST_UNCORR;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syndrome_corrector.sv
// tb_syndrome_corrector: directed vector bench for syndrome_corrector (H column j = j+1)
module tb_syndrome_corrector;
    logic        clk = 0, rst = 1;
    logic [31:0] h_matrix_in, h_ref;
    logic [7:0]  word_in = 0;
    logic [3:0]  syndrome_in = 0;
    logic        in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0]  word_out, word_out2;
    logic [2:0]  err_pos, err_pos2;
    logic [1:0]  status, status2;
    logic [15:0] corr_cnt, uncorr_cnt;
    logic [1:0]  corr_cnt2, uncorr_cnt2;
    int tests = 0, failed = 0, exp_corr = 0, exp_unc = 0;

    always #5 clk = ~clk;

    syndrome_corrector dut (
        .clk(clk), .rst(rst), .h_matrix_in(h_matrix_in), .word_in(word_in),
        .syndrome_in(syndrome_in), .in_valid(in_valid), .in_ready(in_ready),
        .word_out(word_out), .err_pos(err_pos), .status(status), .out_valid(out_valid),
        .out_ready(out_ready), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    syndrome_corrector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .h_matrix_in(h_matrix_in), .word_in(word_in),
        .syndrome_in(syndrome_in), .in_valid(in_valid), .in_ready(in_ready2),
        .word_out(word_out2), .err_pos(err_pos2), .status(status2), .out_valid(out_valid2),
        .out_ready(out_ready), .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
    );

    typedef struct {
        logic [7:0] w;
        logic [3:0] s;
        logic [7:0] ew;
        logic [2:0] ep;
        logic [1:0] est;
        int         lat;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_timeout", 32'(in_ready), 1);
    endtask

    // drive at negedge so the accept happens at the following posedge
    task automatic accept(input logic [7:0] w, input logic [3:0] s);
        @(negedge clk);
        wait_ready();
        word_in = w;
        syndrome_in = s;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        word_in = ~w;
        syndrome_in = ~s;
        h_matrix_in = '0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        chk("out_valid_drop", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
        h_matrix_in = h_ref;
    endtask

    task automatic run_vec(input int i);
        int lat;
        accept(vecs[i].w, vecs[i].s);
        wait_out(lat);
        if (vecs[i].est == 2'd1) exp_corr++;
        if (vecs[i].est == 2'd2) exp_unc++;
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        chk($sformatf("v%0d_word", i), 32'(word_out), 32'(vecs[i].ew));
        chk($sformatf("v%0d_pos", i), 32'(err_pos), 32'(vecs[i].ep));
        chk($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].est));
        chk($sformatf("v%0d_corr_cnt", i), 32'(corr_cnt), 32'(exp_corr));
        chk($sformatf("v%0d_uncorr_cnt", i), 32'(uncorr_cnt), 32'(exp_unc));
        release_out();
    endtask

    initial begin
        int lat, seen;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++)
                h_ref[8*r+j] = ((j + 1) >> r) & 1;
        h_matrix_in = h_ref;
        vecs[0] = '{8'hA5, 4'h0, 8'hA5, 3'd0, 2'd0, 1};
        vecs[1] = '{8'hA5, 4'h3, 8'hA1, 3'd2, 2'd1, 4};
        vecs[2] = '{8'h3C, 4'hF, 8'h3C, 3'd0, 2'd2, 9};
        vecs[3] = '{8'h00, 4'h1, 8'h01, 3'd0, 2'd1, 2};
        vecs[4] = '{8'hFF, 4'h8, 8'h7F, 3'd7, 2'd1, 9};
        vecs[5] = '{8'h12, 4'h5, 8'h02, 3'd4, 2'd1, 6};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_word", 32'(word_out), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_corr_cnt", 32'(corr_cnt), 0);
        for (int i = 0; i < 6; i++) run_vec(i);

        // result held under backpressure while a second word waits
        accept(8'hA5, 4'h3);
        h_matrix_in = h_ref;
        wait_out(lat);
        exp_corr++;
        word_in = 8'h0F;
        syndrome_in = 4'h0;
        in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_word", 32'(word_out), 32'hA1);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        chk("bp_idle", 32'(in_ready), 1);
        chk("bp_gap", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 0;
        @(negedge clk);
        chk("bp_second_valid", 32'(out_valid), 1);
        chk("bp_second_word", 32'(word_out), 32'h0F);
        chk("bp_second_status", 32'(status), 0);
        release_out();

        // reset mid-search drops the word
        accept(8'hA5, 4'h3);
        h_matrix_in = h_ref;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        exp_corr = 0;
        exp_unc = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("rst_mid_no_out", 32'(seen), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        chk("rst_mid_corr_cnt", 32'(corr_cnt), 0);
        chk("rst_mid_uncorr_cnt", 32'(uncorr_cnt), 0);

        // 2-bit counter saturation
        for (int n = 1; n <= 5; n++) begin
            accept(8'h00, 4'h1);
            h_matrix_in = h_ref;
            wait_out(lat);
            chk($sformatf("sat_corr_cnt_%0d", n), 32'(corr_cnt2), 32'(n > 3 ? 3 : n));
            release_out();
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
